// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage definitions: bubble word, fetch FSM encodings and word-address widths.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD         = '0;
  localparam int unsigned BYTE_OFFSET_BITS = 2;
  localparam int unsigned WORD_ADDR_BITS   = 32 - BYTE_OFFSET_BITS;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_ifid.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word, otherwise hold.
module ifid_pipeline_reg
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= fetch_instr;
      pc_plus4 <= fetch_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC, next-PC selection, fetch FSM with sticky fault, and delivered-instruction counter.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_plus4, next_pc;
  logic         redirect, pc_bad;
  logic         pc_load, ifid_load, ifid_flush, fault_set, count_inc;

  assign Address  = pc;
  assign pc_plus4 = pc + 32'd4;
  assign redirect = BranchTaken | Jump;

  always_comb begin
    if (BranchTaken)  next_pc = BranchTarget;
    else if (Jump)    next_pc = JumpTarget;
    else if (Stall)   next_pc = pc;
    else              next_pc = pc_plus4;
  end

  // Sequential overflow past the last word is caught here too, so PC never wraps silently.
  assign pc_bad = (next_pc[BYTE_OFFSET_BITS-1:0] != '0) ||
                  ({{BYTE_OFFSET_BITS{1'b0}}, next_pc[31:BYTE_OFFSET_BITS]} >= 32'(IMEM_WORDS));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= FS_BOOT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FS_BOOT:  state_next = FS_RUN;
      FS_RUN:   state_next = pc_bad ? FS_FAULT : FS_RUN;
      FS_FAULT: state_next = FS_FAULT;
      default:  state_next = FS_BOOT;
    endcase
  end

  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    fault_set  = 1'b0;
    count_inc  = 1'b0;
    case (state)
      FS_RUN: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (!Stall) begin
          ifid_load = 1'b1;
          count_inc = 1'b1;
        end
        if (pc_bad) fault_set = 1'b1;
        else        pc_load   = 1'b1;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc         <= RESET_PC;
      FetchFault <= 1'b0;
      FetchCount <= '0;
    end else begin
      if (pc_load)   pc <= next_pc;
      if (fault_set) FetchFault <= 1'b1;
      if (count_inc && (FetchCount != '1)) FetchCount <= FetchCount + 32'd1;
    end
  end

  ifid_pipeline_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk           (Clk),
    .rst_n         (Rst),
    .load          (ifid_load),
    .flush         (ifid_flush),
    .fetch_instr   (Instruction),
    .fetch_pc_plus4(pc_plus4),
    .instr         (IFID_Instr),
    .pc_plus4      (IFID_PCPlus4),
    .valid         (IFID_Valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a behavioural model predicts every cycle's outputs.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0;
  logic [31:0] Address, Instruction, IFID_Instr, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid, FetchFault;

  logic [31:0] imem [256];

  typedef struct {
    logic [31:0] addr, instr, pc4, count;
    logic        valid, fault;
  } exp_t;
  exp_t sb_q[$];

  // model state: 0 boot, 1 run, 2 fault
  int unsigned m_st;
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_fault;

  int unsigned checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  assign Instruction = imem[Address[9:2]];

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(256),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .Address(Address), .Instruction(Instruction),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .FetchFault(FetchFault), .FetchCount(FetchCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_fault = 1'b0; m_count = '0;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic apply_reset();
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    check("rst_addr",  Address, 32'h0);
    check("rst_instr", IFID_Instr, 32'h0);
    check("rst_pc4",   IFID_PCPlus4, 32'h0);
    check("rst_valid", {31'b0, IFID_Valid}, 32'h0);
    check("rst_fault", {31'b0, FetchFault}, 32'h0);
    check("rst_count", FetchCount, 32'h0);
    model_reset();
    Rst = 1'b1;
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    logic [31:0] npc, cur_word;
    exp_t e, o;
    @(negedge Clk);
    Stall = st; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
    cur_word = imem[m_pc[9:2]];
    if (m_st == 0) begin
      m_st = 1; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (m_st == 1) begin
      npc = br ? bt : (jp ? jt : (st ? m_pc : m_pc + 32'd4));
      if (br || jp) begin
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      end else if (!st) begin
        m_instr = cur_word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end
      if (npc[1:0] != 2'b00 || npc >= 32'h0000_0400) begin
        m_st = 2; m_fault = 1'b1;
      end else begin
        m_pc = npc;
      end
    end else begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.count = m_count;
    e.valid = m_valid; e.fault = m_fault;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      o = sb_q.pop_front();
      check("addr",  Address, o.addr);
      check("instr", IFID_Instr, o.instr);
      check("pc4",   IFID_PCPlus4, o.pc4);
      check("valid", {31'b0, IFID_Valid}, {31'b0, o.valid});
      check("fault", {31'b0, FetchFault}, {31'b0, o.fault});
      check("count", FetchCount, o.count);
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h2400_0000 | (i * 32'h0001_0003);
    model_reset();

    // boot and sequential fetch
    apply_reset();
    run(5);
    check("seq_addr",  Address, 32'h10);
    check("seq_count", FetchCount, 32'd4);

    // stall three cycles at 0x10, then resume
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
    check("stall_addr", Address, 32'h10);
    run(2);
    check("resume_addr", Address, 32'h18);

    // branch beats jump and stall
    step(1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    check("br_addr",  Address, 32'h40);
    check("br_valid", {31'b0, IFID_Valid}, 32'h0);
    check("br_instr", IFID_Instr, 32'h0);
    run(3);
    step(1'b0, 1'b0, '0, 1'b1, 32'h80);
    run(2);

    // jump to the last word, then run off the end of memory
    step(1'b0, 1'b0, '0, 1'b1, 32'h3FC);
    run(1);
    check("end_valid", {31'b0, IFID_Valid}, 32'h1);
    check("end_fault", {31'b0, FetchFault}, 32'h1);
    run(3);
    check("end_addr", Address, 32'h3FC);

    // misaligned jump, stall during fault ignored
    apply_reset();
    run(3);
    step(1'b0, 1'b0, '0, 1'b1, 32'h22);
    check("mis_fault", {31'b0, FetchFault}, 32'h1);
    check("mis_addr",  Address, 32'h8);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    run(2);

    // out-of-range branch while stalled
    apply_reset();
    run(2);
    step(1'b1, 1'b1, 32'h400, 1'b0, '0);
    run(2);
    apply_reset();
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
